// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide unit.
// This file holds the M-extension funct3 codes, the FSM encoding, the operand constants and the op decode.
package rv32_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] XLEN_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] XLEN_ALL_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic is_div;
    logic rs1_signed;
    logic rs2_signed;
    logic rem_sel;
  } mop_dec_t;

  // rem_sel marks REM/REMU, whose result sign follows the dividend only.
  function automatic mop_dec_t decode_mop(input logic [2:0] op);
    mop_dec_t d;
    d.is_div     = op[2];
    d.rs1_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
    d.rs2_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    d.rem_sel    = op[2] & op[1];
    return d;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit.
// The pipeline drives i_*, and the unit drives o_*.
// Handshake: i_valid is held by ID/EX until the instruction leaves EX. The unit accepts on an IDLE
// edge with i_flush low. o_busy stalls upstream until the DONE cycle. o_done qualifies o_result/o_rd.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1_val;
  logic [XLEN-1:0] i_rs2_val;
  logic [4:0]      i_rd;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;
  logic [1:0]      o_dbg_state;

  modport master (
    output i_valid, i_op, i_rs1_val, i_rs2_val, i_rd, i_flush,
    input  o_busy, o_done, o_result, o_rd, o_dbg_state
  );

  modport slave (
    input  i_valid, i_op, i_rs1_val, i_rs2_val, i_rd, i_flush,
    output o_busy, o_done, o_result, o_rd, o_dbg_state
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It uses one 64-bit shift register for shift-add multiply and
// restoring divide, and it works on operand magnitudes with a sign fix-up at the end.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]        r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd, r_out_rd;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb, r_result;
  logic              r_neg, r_done;

  mop_dec_t          w_dec;
  logic              w_accept, w_a_neg, w_b_neg, w_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res;

  always_comb begin
    w_dec     = decode_mop(bus.i_op);
    w_accept  = (r_state == ST_IDLE) & bus.i_valid & ~bus.i_flush;
    w_a_neg   = w_dec.rs1_signed & bus.i_rs1_val[XLEN-1];
    w_b_neg   = w_dec.rs2_signed & bus.i_rs2_val[XLEN-1];
    w_mag_a   = w_a_neg ? -bus.i_rs1_val : bus.i_rs1_val;
    w_mag_b   = w_b_neg ? -bus.i_rs2_val : bus.i_rs2_val;
    w_neg     = w_dec.rem_sel ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div0    = w_dec.is_div & (bus.i_rs2_val == '0);
    // Only signed DIV/REM (funct3 bit 0 clear) can overflow.
    w_ovf     = w_dec.is_div & ~bus.i_op[0] & (bus.i_rs1_val == XLEN_INT_MIN) &
                (bus.i_rs2_val == XLEN_ALL_ONES);
    w_special = w_div0 | w_ovf;
    if (w_div0) w_special_res = bus.i_op[1] ? bus.i_rs1_val : XLEN_ALL_ONES;
    else        w_special_res = bus.i_op[1] ? '0 : XLEN_INT_MIN;
  end

  logic [XLEN:0]     w_mul_sum, w_part;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff, w_dres, w_calc_res;
  logic [2*XLEN-1:0] w_acc_step, w_prod;

  // Multiply: the upper half accumulates, and the multiplier shifts out of the lower half.
  // Divide: the upper half holds the partial remainder, and quotient bits enter at the bottom.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_part    = r_acc[2*XLEN-1:XLEN-1];
    w_ge      = w_part >= {1'b0, r_opb};
    w_diff    = w_part[XLEN-1:0] - r_opb;
    if (r_op[2]) w_acc_step = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
    else         w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
    w_prod = r_neg ? -w_acc_step : w_acc_step;
    w_dres = r_op[1] ? w_acc_step[2*XLEN-1:XLEN] : w_acc_step[XLEN-1:0];
    if (r_op[2])                w_calc_res = r_neg ? -w_dres : w_dres;
    else if (r_op[1:0] == 2'd0) w_calc_res = w_prod[XLEN-1:0];
    else                        w_calc_res = w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.i_flush)       w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)  w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_out_rd <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.i_op;
            r_rd  <= bus.i_rd;
            r_neg <= w_neg;
            r_cnt <= CW'(XLEN - 1);
            r_acc <= {{XLEN{1'b0}}, (w_dec.is_div ? w_mag_a : w_mag_b)};
            r_opb <= w_dec.is_div ? w_mag_b : w_mag_a;
            if (w_special) begin
              r_result <= w_special_res;
              r_out_rd <= bus.i_rd;
            end
          end
        end
        ST_CALC: begin
          if (!bus.i_flush) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_calc_res;
              r_out_rd <= r_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = resetn & ((r_state == ST_CALC) | w_accept);
  assign bus.o_done      = r_done & ~bus.i_flush;
  assign bus.o_result    = r_result;
  assign bus.o_rd        = r_out_rd;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written flush / back-to-back / mid-calc reset sequences.
module tb_ex_muldiv_unit;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus();
  ex_muldiv_unit dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic [5:0]  exp_lat;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a negedge: presents the op and follows it to o_done (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit keep_valid,
                        output logic [31:0] res, output logic [4:0] rd_o,
                        output int lat, output int busy_n);
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_rs1_val = a;
    bus.i_rs2_val = b;
    bus.i_rd = rd;
    bus.i_flush = 1'b0;
    #1;
    busy_n = bus.o_busy ? 1 : 0;
    lat = -1;
    res = '0;
    rd_o = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        lat = k;
        res = bus.o_result;
        rd_o = bus.o_rd;
        if (!keep_valid) bus.i_valid = 1'b0;
        break;
      end
    end
    if (lat < 0) bus.i_valid = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.o_done) n++;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  rd_o;
    int lat;
    int busy_n;
    int n_done;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int sel;

    bus.i_valid = 1'b1;
    bus.i_op = OP_MUL;
    bus.i_rs1_val = 32'd5;
    bus.i_rs2_val = 32'd6;
    bus.i_rd = 5'd1;
    bus.i_flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 32'(bus.o_busy), 32'd0);
    check("reset done", 32'(bus.o_done), 32'd0);
    check("reset result", bus.o_result, 32'd0);
    check("reset rd", 32'(bus.o_rd), 32'd0);
    check("reset state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
    bus.i_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 6'd33};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 6'd33};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 6'd33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 6'd33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 6'd33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 6'd33};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         5'd9,  32'd14,        6'd33};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         5'd10, 32'd2,         6'd33};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 6'd1};
    vecs[9]  = '{OP_REMU,   32'd5,          32'd0,         5'd12, 32'd5,         6'd1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 6'd1};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         6'd1};

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0, res, rd_o, lat, busy_n);
      check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d busy cycles", i), 32'(busy_n), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d rd", i), 32'(rd_o), 32'(vecs[i].rd));
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else b = $urandom;
      rd = 5'($urandom_range(1, 31));
      exp_q.push_back(model(op, a, b));
      run_op(op, a, b, rd, 1'b0, res, rd_o, lat, busy_n);
      check($sformatf("rand%0d op%0d %h,%h result", i, op, a, b), res, exp_q.pop_front());
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(model_lat(op, a, b)));
      @(negedge clk);
    end

    // Flush in IDLE blocks accept.
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op = OP_DIVU;
    #1;
    check("idle flush busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    check("idle flush state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    @(negedge clk);

    // Flush at CALC cycle 10.
    bus.i_valid = 1'b1;
    bus.i_op = OP_MUL;
    bus.i_rs1_val = 32'd1234;
    bus.i_rs2_val = 32'd5678;
    bus.i_rd = 5'd20;
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b0;
    #1;
    check("flush cycle done", 32'(bus.o_done), 32'd0);
    @(negedge clk);
    bus.i_flush = 1'b0;
    #1;
    check("post flush busy", 32'(bus.o_busy), 32'd0);
    check("post flush done", 32'(bus.o_done), 32'd0);
    check("post flush state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
    count_dones(40, n_done);
    check("post flush done count", 32'(n_done), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd4, 5'd21, 1'b0, res, rd_o, lat, busy_n);
    check("mul after flush result", res, 32'd12);
    check("mul after flush latency", 32'(lat), 32'd33);
    @(negedge clk);

    // i_valid held through DONE, then back-to-back DIVU.
    run_op(OP_DIV, 32'd20, 32'd3, 5'd22, 1'b1, res, rd_o, lat, busy_n);
    check("held div result", res, 32'd6);
    @(negedge clk);
    check("held div single done", 32'(bus.o_done), 32'd0);
    check("held div back to idle", 32'(bus.o_dbg_state), 32'(ST_IDLE));
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd9, 1'b0, res, rd_o, lat, busy_n);
    check("b2b divu result", res, 32'd3);
    check("b2b divu latency", 32'(lat), 32'd33);
    check("b2b divu rd", 32'(rd_o), 32'd9);
    @(negedge clk);

    // Async reset at CALC cycle 5.
    bus.i_valid = 1'b1;
    bus.i_op = OP_MULHU;
    bus.i_rs1_val = 32'hDEAD_BEEF;
    bus.i_rs2_val = 32'h1234_5678;
    bus.i_rd = 5'd17;
    @(posedge clk);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid reset busy", 32'(bus.o_busy), 32'd0);
    check("mid reset done", 32'(bus.o_done), 32'd0);
    check("mid reset result", bus.o_result, 32'd0);
    check("mid reset rd", 32'(bus.o_rd), 32'd0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    count_dones(40, n_done);
    check("after reset done count", 32'(n_done), 32'd0);
    check("after reset state", 32'(bus.o_dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
